// File: rtl/rx_buf_pkg.sv
// rx_buf_pkg: shared write-state enum and default sizing for the rx frame buffer
package rx_buf_pkg;
  localparam int DEPTH_DEF = 2048;
  localparam int CNT_W_DEF = 16;
  typedef enum logic [1:0] {WR_IDLE, WR_FRAME, WR_DROP} wr_state_t;
endpackage

// File: rtl/rx_buf_ram.sv
// rx_buf_ram: simple dual-port DEPTH x 9 storage with a registered read port
module rx_buf_ram #(
  parameter int DEPTH = 2048,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [8:0]    wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [8:0]    rdata
);
  logic [8:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: store-and-forward frame buffer that drops errored or overflowing frames
module rx_frame_buffer
  import rx_buf_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic                   in_error,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] frame_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic                   overflow
);
  localparam int PW = $clog2(DEPTH) + 1;
  wr_state_t state, state_nxt;
  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, used;
  logic full, wr_en, commit, drop, ovf_c, rd_en, accept, fin;
  assign used = wr_ptr - rd_ptr;
  assign full = used == PW'(DEPTH);
  assign accept = out_valid && out_ready;
  assign fin = accept && out_last;
  assign rd_en = (!out_valid || out_ready) && (rd_ptr != commit_ptr);
  always_comb begin
    state_nxt = state;
    wr_en = 1'b0;
    commit = 1'b0;
    drop = 1'b0;
    ovf_c = 1'b0;
    if (in_valid) begin
      if (state == WR_DROP) begin
        state_nxt = in_last ? WR_IDLE : WR_DROP;
      end else if (in_error || full) begin
        drop = 1'b1;
        ovf_c = full;
        state_nxt = in_last ? WR_IDLE : WR_DROP;
      end else begin
        wr_en = 1'b1;
        commit = in_last;
        state_nxt = in_last ? WR_IDLE : WR_FRAME;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= WR_IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      out_valid <= 1'b0;
      frame_count <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr <= wr_en ? wr_ptr + 1'b1 : drop ? commit_ptr : wr_ptr;
      if (commit) commit_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      out_valid <= rd_en ? 1'b1 : accept ? 1'b0 : out_valid;
      frame_count <= frame_count + PW'(commit) - PW'(fin);
      if (drop && !(&drop_count)) drop_count <= drop_count + 1'b1;
      overflow <= ovf_c;
    end
  rx_buf_ram #(.DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr[PW-2:0]),
    .wdata ({in_last, in_data}),
    .re    (rd_en),
    .raddr (rd_ptr[PW-2:0]),
    .rdata ({out_last, out_data})
  );
endmodule

// File: tb/tb_rx_frame_buffer.sv
// tb_rx_frame_buffer: directed self-checking bench for rx_frame_buffer
module tb_rx_frame_buffer;
  logic clk, rst, in_valid, in_last, in_error, out_valid, out_last, out_ready, overflow;
  logic [7:0] in_data, out_data;
  logic [6:0] frame_count;
  logic [1:0] drop_count;
  logic [8:0] rx_q [$];
  int n_tests, n_fail, ovf_cnt, fc_max;
  rx_frame_buffer #(.DEPTH(64), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_last     (in_last),
    .in_error    (in_error),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .frame_count (frame_count),
    .drop_count  (drop_count),
    .overflow    (overflow)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (out_valid && out_ready) rx_q.push_back({out_last, out_data});
    if (overflow) ovf_cnt++;
    if (int'(frame_count) > fc_max) fc_max = int'(frame_count);
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send_frame(input int len, input int err_at, input logic [7:0] seed, input bit rnd);
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_data = 8'(seed + i);
      in_last = (i == len - 1);
      in_error = (i == err_at);
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    in_error = 1'b0;
  endtask
  task automatic wait_drain(input string tag, input bit rnd);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 1000 && !done; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      done = (frame_count == 0) && !out_valid;
    end
    out_ready = 1'b1;
    chk({tag, "_drain"}, 32'(done), 32'd1);
  endtask
  task automatic check_rx(input string tag, input int len, input logic [7:0] seed);
    int bad;
    logic [8:0] e;
    bad = 0;
    chk({tag, "_len"}, 32'(rx_q.size()), 32'(len));
    for (int i = 0; i < rx_q.size(); i++) begin
      e = {(i == len - 1), 8'(seed + i)};
      if (rx_q[i] !== e) bad++;
    end
    chk({tag, "_bytes"}, 32'(bad), 32'd0);
    rx_q.delete();
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    ovf_cnt = 0;
    fc_max = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_last = 1'b0;
    in_error = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_frame(64, -1, 8'h10, 1'b0);
    chk("lat_n1_valid", 32'(out_valid), 32'd0);
    chk("commit_fc", 32'(frame_count), 32'd1);
    @(posedge clk); #1;
    chk("lat_n2_valid", 32'(out_valid), 32'd1);
    chk("first_byte", 32'(out_data), 32'h10);
    wait_drain("clean64", 1'b0);
    chk("clean64_fc", 32'(frame_count), 32'd0);
    check_rx("clean64", 64, 8'h10);
    send_frame(100, 49, 8'h40, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chk("err_no_out", 32'(rx_q.size()), 32'd0);
    chk("err_drop", 32'(drop_count), 32'd1);
    chk("err_fc", 32'(frame_count), 32'd0);
    chk("err_no_ovf", 32'(ovf_cnt), 32'd0);
    send_frame(64, -1, 8'h80, 1'b0);
    wait_drain("after_err", 1'b0);
    check_rx("after_err", 64, 8'h80);
    out_ready = 1'b0;
    ovf_cnt = 0;
    send_frame(40, -1, 8'h01, 1'b0);
    send_frame(40, -1, 8'h50, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_pulses", 32'(ovf_cnt), 32'd1);
    chk("ovf_drop", 32'(drop_count), 32'd2);
    chk("ovf_fc", 32'(frame_count), 32'd1);
    out_ready = 1'b1;
    wait_drain("ovf_first", 1'b0);
    check_rx("ovf_first", 40, 8'h01);
    send_frame(1, 0, 8'hEE, 1'b0);
    chk("drop3", 32'(drop_count), 32'd3);
    send_frame(5, 4, 8'hEE, 1'b0);
    chk("drop_sat", 32'(drop_count), 32'd3);
    chk("drop_no_ovf", 32'(ovf_cnt), 32'd1);
    fc_max = 0;
    for (int k = 0; k < 3; k++) begin
      send_frame(60, -1, 8'(8'h20 + 8'(k * 64)), 1'b1);
      wait_drain("wrap", 1'b1);
      check_rx("wrap", 60, 8'(8'h20 + 8'(k * 64)));
    end
    chk("wrap_fc_max", 32'(fc_max), 32'd1);
    chk("wrap_fc_end", 32'(frame_count), 32'd0);
    out_ready = 1'b0;
    send_frame(20, -1, 8'hA0, 1'b0);
    @(posedge clk); #1;
    chk("hold_valid", 32'(out_valid), 32'd1);
    chk("hold_data", 32'(out_data), 32'hA0);
    for (int i = 0; i < 29; i++) begin
      in_valid = 1'b1;
      in_data = 8'(8'h30 + i);
      @(posedge clk); #1;
    end
    in_data = 8'h4D;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_fc", 32'(frame_count), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    rx_q.delete();
    @(posedge clk); #1;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst_empty", 32'(rx_q.size()), 32'd0);
    send_frame(64, -1, 8'hC0, 1'b0);
    wait_drain("post_rst", 1'b0);
    check_rx("post_rst", 64, 8'hC0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
